// File: rtl/ex_issue_stage.sv
// ex_issue_stage
//   ID/EX pipeline register and operand-issue block. Holds one decoded
//   instruction for the EX stage and resolves RAW hazards by forwarding
//   from MEM and WB. A load-use hazard inserts a single bubble.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   dec_*                decoded instruction offered with dec_valid/dec_ready
//   ex_ready             EX consumes the held instruction this cycle
//   flush                kill the held instruction and any accept
//   mem_fwd_*, mem_is_load, wb_fwd_*   forwarding sources
//   issue_valid/rd/is_load             held instruction status
//   alu_in1, alu_in2, ALUop, funct, invert   EX operand/control interface
//   fwd_sel1, fwd_sel2   operand source: 00 reg, 01 MEM, 10 WB
module ex_issue_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [REGW-1:0] dec_rs1,
  input  logic [REGW-1:0] dec_rs2,
  input  logic [REGW-1:0] dec_rd,
  input  logic [XLEN-1:0] dec_rs1_val,
  input  logic [XLEN-1:0] dec_rs2_val,
  input  logic [XLEN-1:0] dec_imm,
  input  logic            dec_use_imm,
  input  logic            dec_is_load,
  input  logic [2:0]      dec_aluop,
  input  logic [2:0]      dec_funct,
  input  logic            dec_invert,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            mem_fwd_valid,
  input  logic [REGW-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            mem_is_load,
  input  logic            wb_fwd_valid,
  input  logic [REGW-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            issue_valid,
  output logic [REGW-1:0] issue_rd,
  output logic            issue_is_load,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      ALUop,
  output logic [2:0]      funct,
  output logic            invert,
  output logic [1:0]      fwd_sel1,
  output logic [1:0]      fwd_sel2
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic            vld_p1;
  logic [REGW-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [XLEN-1:0] rs1_val_p1, rs2_val_p1, imm_p1;
  logic            use_imm_p1, is_load_p1;
  logic [2:0]      aluop_p1, funct_p1;
  logic            invert_p1;

  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] fwd1, fwd2;
  logic [1:0]      sel1, sel2;

  // Forwarding source for one register. A load in MEM has no data yet, so it
  // is skipped; the load-use bubble guarantees the consumer sees it in WB.
  function automatic logic [1:0] fwd_src(input logic [REGW-1:0] r,
                                         input logic mv, input logic [REGW-1:0] mrd,
                                         input logic mld,
                                         input logic wv, input logic [REGW-1:0] wrd);
    if (r != '0 && mv && !mld && mrd == r) return SEL_MEM;
    if (r != '0 && wv && wrd == r)         return SEL_WB;
    return SEL_REG;
  endfunction

  function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel,
                                              input logic [XLEN-1:0] v,
                                              input logic [XLEN-1:0] md,
                                              input logic [XLEN-1:0] wd);
    case (sel)
      SEL_MEM: return md;
      SEL_WB:  return wd;
      default: return v;
    endcase
  endfunction

  always_comb begin
    sel1 = fwd_src(rs1_p1, mem_fwd_valid, mem_fwd_rd, mem_is_load, wb_fwd_valid, wb_fwd_rd);
    sel2 = fwd_src(rs2_p1, mem_fwd_valid, mem_fwd_rd, mem_is_load, wb_fwd_valid, wb_fwd_rd);
    fwd1 = fwd_mux(sel1, rs1_val_p1, mem_fwd_data, wb_fwd_data);
    fwd2 = fwd_mux(sel2, rs2_val_p1, mem_fwd_data, wb_fwd_data);
  end

  // Load-use: the held load's data is not available to a dependent
  // instruction entering EX next cycle.
  assign hazard = vld_p1 && is_load_p1 && (rd_p1 != '0) &&
                  ((dec_rs1 == rd_p1) || (!dec_use_imm && (dec_rs2 == rd_p1)));

  assign dec_ready = rst_n && (!vld_p1 || ex_ready) && !hazard && !flush;
  assign accept    = dec_valid && dec_ready;

  // ---- ID/EX register (p1) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      rs1_val_p1 <= '0;
      rs2_val_p1 <= '0;
      imm_p1     <= '0;
      use_imm_p1 <= 1'b0;
      is_load_p1 <= 1'b0;
      aluop_p1   <= '0;
      funct_p1   <= '0;
      invert_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (vld_p1 && !ex_ready) begin
      // Capture forwarded operands so they survive the producer retiring.
      rs1_val_p1 <= fwd1;
      rs2_val_p1 <= fwd2;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      rs1_p1     <= dec_rs1;
      rs2_p1     <= dec_rs2;
      rd_p1      <= dec_rd;
      rs1_val_p1 <= dec_rs1_val;
      rs2_val_p1 <= dec_rs2_val;
      imm_p1     <= dec_imm;
      use_imm_p1 <= dec_use_imm;
      is_load_p1 <= dec_is_load;
      aluop_p1   <= dec_aluop;
      funct_p1   <= dec_funct;
      invert_p1  <= dec_invert;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign issue_valid   = vld_p1;
  assign issue_rd      = rd_p1;
  assign issue_is_load = is_load_p1;
  assign alu_in1       = fwd1;
  assign alu_in2       = use_imm_p1 ? imm_p1 : fwd2;
  assign fwd_sel1      = sel1;
  assign fwd_sel2      = use_imm_p1 ? SEL_REG : sel2;
  assign ALUop         = aluop_p1;
  assign funct         = funct_p1;
  assign invert        = invert_p1;

endmodule

// File: tb/tb_ex_issue_stage.sv
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm;
  logic        dec_use_imm, dec_is_load;
  logic [2:0]  dec_aluop, dec_funct;
  logic        dec_invert;
  logic        ex_ready, flush;
  logic        mem_fwd_valid, mem_is_load;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_valid;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        issue_valid, issue_is_load;
  logic [4:0]  issue_rd;
  logic [31:0] alu_in1, alu_in2;
  logic [2:0]  ALUop, funct;
  logic        invert;
  logic [1:0]  fwd_sel1, fwd_sel2;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] a1;
    logic [31:0] a2;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [2:0]  op;
    logic [2:0]  fn;
    logic        inv;
    logic [4:0]  rd;
    logic        ld;
  } exp_t;

  exp_t sb[$];

  ex_issue_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .dec_imm(dec_imm),
    .dec_use_imm(dec_use_imm), .dec_is_load(dec_is_load),
    .dec_aluop(dec_aluop), .dec_funct(dec_funct), .dec_invert(dec_invert),
    .ex_ready(ex_ready), .flush(flush),
    .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd),
    .mem_fwd_data(mem_fwd_data), .mem_is_load(mem_is_load),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_load(issue_is_load),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .ALUop(ALUop), .funct(funct), .invert(invert),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                       input logic ui, input logic ld, input logic [2:0] op,
                       input logic [2:0] fn, input logic inv);
    dec_valid   = 1'b1;
    dec_rs1     = rs1;
    dec_rs2     = rs2;
    dec_rd      = rd;
    dec_rs1_val = v1;
    dec_rs2_val = v2;
    dec_imm     = imm;
    dec_use_imm = ui;
    dec_is_load = ld;
    dec_aluop   = op;
    dec_funct   = fn;
    dec_invert  = inv;
  endtask

  task automatic push(input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] s1,
                      input logic [1:0] s2, input logic [2:0] op, input logic [2:0] fn,
                      input logic inv, input logic [4:0] rd, input logic ld);
    exp_t e;
    e = '{a1: a1, a2: a2, s1: s1, s2: s2, op: op, fn: fn, inv: inv, rd: rd, ld: ld};
    sb.push_back(e);
  endtask

  // Pop the oldest expected issue and compare against the EX interface.
  task automatic pop_check(input string tag);
    exp_t e;
    tests++;
    assert (sb.size() != 0) else begin
      fails++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'b0, issue_valid}, 32'd1);
      chk({tag, "_in1"},   alu_in1, e.a1);
      chk({tag, "_in2"},   alu_in2, e.a2);
      chk({tag, "_sel1"},  {30'b0, fwd_sel1}, {30'b0, e.s1});
      chk({tag, "_sel2"},  {30'b0, fwd_sel2}, {30'b0, e.s2});
      chk({tag, "_op"},    {29'b0, ALUop}, {29'b0, e.op});
      chk({tag, "_fn"},    {29'b0, funct}, {29'b0, e.fn});
      chk({tag, "_inv"},   {31'b0, invert}, {31'b0, e.inv});
      chk({tag, "_rd"},    {27'b0, issue_rd}, {27'b0, e.rd});
      chk({tag, "_ld"},    {31'b0, issue_is_load}, {31'b0, e.ld});
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    dec_valid = 1'b1;
    mem_fwd_valid = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0; mem_is_load = 1'b0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
    #1;
    chk("rst_valid", {31'b0, issue_valid}, 32'd0);
    chk("rst_ready", {31'b0, dec_ready}, 32'd0);
    chk("rst_op", {29'b0, ALUop}, 32'd0);
    chk("rst_in1", alu_in1, 32'd0);
    chk("rst_in2", alu_in2, 32'd0);
    dec_valid = 1'b0;
    tick(); tick();
    @(negedge clk) rst_n = 1'b1;

    // 1: back-to-back independent ops
    drive(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0);
    #1 chk("t1_ready", {31'b0, dec_ready}, 32'd1);
    push(32'd5, 32'd7, 2'b00, 2'b00, 3'd2, 3'd0, 1'b0, 5'd3, 1'b0);
    tick();
    pop_check("t1a");
    drive(5'd7, 5'd8, 5'd9, 32'h100, 32'h200, 32'hFFFF_FFFC, 1'b1, 1'b0, 3'd3, 3'd7, 1'b1);
    #1 chk("t1_ready2", {31'b0, dec_ready}, 32'd1);
    push(32'h100, 32'hFFFF_FFFC, 2'b00, 2'b00, 3'd3, 3'd7, 1'b1, 5'd9, 1'b0);
    tick();
    pop_check("t1b");

    // 2: MEM priority over WB, then WB alone, then MEM load skipped
    drive(5'd4, 5'd10, 5'd11, 32'hAAAA, 32'hBBBB, 32'h0, 1'b0, 1'b0, 3'd1, 3'd2, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'h11;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h22;
    push(32'h11, 32'hBBBB, 2'b01, 2'b00, 3'd1, 3'd2, 1'b0, 5'd11, 1'b0);
    tick();
    pop_check("t2");
    mem_fwd_valid = 1'b0;
    #1 chk("t2_wb_in1", alu_in1, 32'h22);
    chk("t2_wb_sel1", {30'b0, fwd_sel1}, 32'd2);
    mem_fwd_valid = 1'b1; mem_is_load = 1'b1;
    #1 chk("t2_memld_in1", alu_in1, 32'h22);
    mem_is_load = 1'b0;

    // 3: x0 never forwards
    drive(5'd12, 5'd0, 5'd13, 32'h5, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    mem_fwd_valid = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hDEAD;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd0; wb_fwd_data = 32'hBEEF;
    push(32'h5, 32'h0, 2'b00, 2'b00, 3'd0, 3'd0, 1'b0, 5'd13, 1'b0);
    tick();
    pop_check("t3");

    // 4: load-use inserts one bubble, dependent then takes WB data
    mem_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
    drive(5'd1, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h8, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0);
    push(32'h1000, 32'h8, 2'b00, 2'b00, 3'd0, 3'd2, 1'b0, 5'd5, 1'b1);
    tick();
    pop_check("t4_lw");
    drive(5'd5, 5'd6, 5'd7, 32'h0, 32'h3, 32'h0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    #1 chk("t4_hazard_ready", {31'b0, dec_ready}, 32'd0);
    tick();
    chk("t4_bubble", {31'b0, issue_valid}, 32'd0);
    chk("t4_ready_back", {31'b0, dec_ready}, 32'd1);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h99;
    push(32'h99, 32'h3, 2'b10, 2'b00, 3'd0, 3'd0, 1'b0, 5'd7, 1'b0);
    tick();
    pop_check("t4_dep");

    // 5: stall captures WB data that disappears after one cycle
    wb_fwd_valid = 1'b0;
    drive(5'd6, 5'd0, 5'd8, 32'h0, 32'h0, 32'h7, 1'b1, 1'b0, 3'd4, 3'd1, 1'b0);
    push(32'h0, 32'h7, 2'b00, 2'b00, 3'd4, 3'd1, 1'b0, 5'd8, 1'b0);
    tick();
    pop_check("t5_acc");
    ex_ready = 1'b0;
    drive(5'd1, 5'd0, 5'd2, 32'h77, 32'h0, 32'h0, 1'b1, 1'b0, 3'd6, 3'd0, 1'b0);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h42;
    #1 chk("t5_ready_c1", {31'b0, dec_ready}, 32'd0);
    chk("t5_fwd_c1", alu_in1, 32'h42);
    tick();
    wb_fwd_valid = 1'b0;
    #1 chk("t5_hold_c2", alu_in1, 32'h42);
    chk("t5_sel_c2", {30'b0, fwd_sel1}, 32'd0);
    chk("t5_ready_c2", {31'b0, dec_ready}, 32'd0);
    tick();
    chk("t5_hold_c3", alu_in1, 32'h42);
    chk("t5_valid_c3", {31'b0, issue_valid}, 32'd1);
    tick();
    ex_ready = 1'b1;
    #1 chk("t5_release_in1", alu_in1, 32'h42);
    chk("t5_release_ready", {31'b0, dec_ready}, 32'd1);
    push(32'h77, 32'h0, 2'b00, 2'b00, 3'd6, 3'd0, 1'b0, 5'd2, 1'b0);
    tick();
    pop_check("t5_next");

    // 6: flush blocks accept; reset mid-hold discards
    drive(5'd3, 5'd4, 5'd9, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 3'd7, 3'd0, 1'b0);
    flush = 1'b1;
    #1 chk("t6_flush_ready", {31'b0, dec_ready}, 32'd0);
    tick();
    chk("t6_flush_valid", {31'b0, issue_valid}, 32'd0);
    flush = 1'b0;
    drive(5'd1, 5'd0, 5'd10, 32'h33, 32'h0, 32'h0, 1'b1, 1'b0, 3'd5, 3'd3, 1'b1);
    push(32'h33, 32'h0, 2'b00, 2'b00, 3'd5, 3'd3, 1'b1, 5'd10, 1'b0);
    tick();
    pop_check("t6_acc");
    ex_ready = 1'b0; dec_valid = 1'b0;
    tick();
    chk("t6_hold_valid", {31'b0, issue_valid}, 32'd1);
    chk("t6_hold_in1", alu_in1, 32'h33);
    #2 rst_n = 1'b0;
    #1 chk("t6_rst_valid", {31'b0, issue_valid}, 32'd0);
    chk("t6_rst_op", {29'b0, ALUop}, 32'd0);
    chk("t6_rst_in1", alu_in1, 32'd0);
    chk("t6_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
